ex_mem_skid_reg: RTL and testbench
==================================

Name: ex_mem_skid_reg

Overview:
- Parametrised EX→MEM pipeline boundary register with a two-entry skid buffer and valid/ready handshakes on both sides.
- Replaces the fixed-width, stall-only EX/MEM latch. Adds backpressure without a combinational ready path, a synchronous flush, and bubble (NOP) insertion.
- Sits between the execute stage (producer) and the memory-access stage (consumer).

Parameters:
- REG_W, 32, width of write-back data and store data.
- RADDR_W, 5, destination register address width.
- MADDR_W, 17, RAM address width.
- ALUOP_W, 8, ALU opcode width.
- NOP_ALUOP, 0, ALU opcode value presented during a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous flush; discards all held and incoming entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  block can accept an entry this cycle.
- ex_wd  in  RADDR_W  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  REG_W  ALU result / write-back data.
- mem_addr_i  in  MADDR_W  memory address.
- mem_write_data_i  in  REG_W  store data.
- mem_rw_i  in  1  1 = memory write, 0 = read/none.
- aluop_i  in  ALUOP_W  ALU opcode.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM consumes the entry this cycle.
- mem_wd, mem_wreg, mem_wdata, mem_addr_o, mem_write_data_o, mem_rw_o, aluop_o  out  same widths as the inputs  registered payload.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset state: EMPTY, out_valid=0, occupancy=0.
  - Payload outputs take bubble values: mem_wd=0, mem_wreg=0, mem_wdata=0, mem_addr_o=0, mem_write_data_o=0, mem_rw_o=0, aluop_o=NOP_ALUOP.
  - Skid register is cleared.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !rst & (state != FULL). It depends only on state, never on out_ready or in_valid.
- Storage:
  - All outputs are driven from the main register. No combinational path exists from any input to payload outputs or out_valid.
  - out_valid = (state != EMPTY).
- State machine: EMPTY, ONE, FULL.
  - EMPTY, in_fire: main ← inputs; go to ONE.
  - ONE, in_fire & out_fire: main ← inputs; stay in ONE.
  - ONE, in_fire & !out_fire: skid ← inputs; go to FULL.
  - ONE, !in_fire & out_fire: main ← bubble; go to EMPTY.
  - FULL, out_fire: main ← skid, skid ← bubble; go to ONE. in_ready is 0 in FULL, so no input is accepted.
  - Any state with neither fire: hold all registers.
- Ordering: strict FIFO; entries leave in acceptance order with no loss or duplication.
- Bubble rule: whenever out_valid=0, payload outputs equal the bubble values, so MEM never sees a stale write enable or store.
- flush_i (priority below rst, above everything else): next state EMPTY, main and skid ← bubble. A same-cycle in_fire is discarded and a same-cycle out_fire is still considered consumed.
- rst mid-operation: wins over flush_i and all handshakes; held entries are lost.
- occupancy is 0/1/2 for EMPTY/ONE/FULL and updates in the same edge as the state.
- Throughput: one entry per cycle sustained when out_ready=1. Latency is 1 cycle from in_fire to out_valid.

Test Plan:
- Reset then stream: rst 2 cycles, then 4 back-to-back entries with ex_wd=1..4, out_ready=1.
  - Required: out_valid rises 1 cycle after the first in_fire; mem_wd shows 1, 2, 3, 4 on consecutive cycles; in_ready stays 1; occupancy stays 1.
- Backpressure:
  - Stimulus: out_ready=0 while sending wd=5, then wd=6.
  - Required: occupancy goes 1→2; in_ready=0 the cycle after wd=6 is accepted; mem_wd stays 5.
  - Then raise out_ready: mem_wd=5, then 6, then bubble (out_valid=0, mem_wreg=0, aluop_o=NOP_ALUOP).
- Flush in FULL: fill both entries (mem_rw=1 store), assert flush_i with in_valid=1.
  - Required: next cycle occupancy=0, out_valid=0, mem_rw_o=0; the flushed-cycle input never appears at the outputs.
- Simultaneous fire in ONE:
  - Stimulus: hold entry wd=7, then in_valid=1 with wd=8 and out_ready=1 in the same cycle.
  - Required: next cycle mem_wd=8, occupancy=1.
- Reset mid-FULL: rst with two entries held and in_valid=1.
  - Required: next cycle all outputs at bubble/reset values; in_ready=0 during rst and 1 the cycle after.
- Random valid/ready for 10k cycles against a scoreboard.
  - Required: order preserved, no loss or duplication; no payload change while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary: registered outputs with a two-entry skid buffer,
// valid/ready on both sides, synchronous flush and bubble insertion when empty.
module ex_mem_skid_reg #(
  parameter int                 REG_W     = 32,
  parameter int                 RADDR_W   = 5,
  parameter int                 MADDR_W   = 17,
  parameter int                 ALUOP_W   = 8,
  parameter logic [ALUOP_W-1:0] NOP_ALUOP = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] ex_wd,
  input  logic               ex_wreg,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [MADDR_W-1:0] mem_addr_i,
  input  logic [REG_W-1:0]   mem_write_data_i,
  input  logic               mem_rw_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] mem_wd,
  output logic               mem_wreg,
  output logic [REG_W-1:0]   mem_wdata,
  output logic [MADDR_W-1:0] mem_addr_o,
  output logic [REG_W-1:0]   mem_write_data_o,
  output logic               mem_rw_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [1:0]         occupancy
);

  localparam int PW = RADDR_W + 1 + REG_W + MADDR_W + REG_W + 1 + ALUOP_W;

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] bubble;
  logic          in_fire, out_fire;

  assign in_pl  = {ex_wd, ex_wreg, ex_wdata, mem_addr_i, mem_write_data_i, mem_rw_i, aluop_i};
  assign bubble = {{(PW-ALUOP_W){1'b0}}, NOP_ALUOP};

  // Ready is a function of registered state only, so no ready path runs through.
  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = bubble;
      skid_d  = bubble;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_pl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_pl;
          end else if (in_fire) begin
            skid_d  = in_pl;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = bubble;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = bubble;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = bubble;
          skid_d  = bubble;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= bubble;
      skid_q  <= bubble;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {mem_wd, mem_wreg, mem_wdata, mem_addr_o, mem_write_data_o, mem_rw_o, aluop_o} = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios plus randomized valid/ready
// traffic compared against a queue-based FIFO reference model.
module tb_ex_mem_skid_reg;

  localparam logic [7:0] NOP = 8'h13;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [16:0] addr;
    logic [31:0] sdata;
    logic        rw;
    logic [7:0]  aluop;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid, in_ready, out_valid, out_ready;
  pl_t         din, dout;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_rw_o;
  logic [31:0] mem_wdata, mem_write_data_o;
  logic [16:0] mem_addr_o;
  logic [7:0]  aluop_o;
  logic [1:0]  occupancy;

  pl_t  q[$];
  pl_t  prev_out;
  logic prev_hold = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(
    .REG_W(32), .RADDR_W(5), .MADDR_W(17), .ALUOP_W(8), .NOP_ALUOP(NOP)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .ex_wd(din.wd), .ex_wreg(din.wreg), .ex_wdata(din.wdata),
    .mem_addr_i(din.addr), .mem_write_data_i(din.sdata), .mem_rw_i(din.rw),
    .aluop_i(din.aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_addr_o(mem_addr_o), .mem_write_data_o(mem_write_data_o),
    .mem_rw_o(mem_rw_o), .aluop_o(aluop_o), .occupancy(occupancy)
  );

  assign dout = {mem_wd, mem_wreg, mem_wdata, mem_addr_o, mem_write_data_o, mem_rw_o, aluop_o};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pl_t bubble();
    pl_t b = '0;
    b.aluop = NOP;
    return b;
  endfunction

  function automatic pl_t mk(input logic [4:0] wd, input logic rw);
    pl_t p;
    p.wd    = wd;
    p.wreg  = 1'b1;
    p.wdata = 32'($urandom());
    p.addr  = 17'($urandom());
    p.sdata = 32'($urandom());
    p.rw    = rw;
    p.aluop = 8'($urandom_range(1, 255));
    return p;
  endfunction

  // One clock: drive inputs after the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic cyc(input logic r, input logic f, input logic iv, input pl_t p, input logic ordy);
    logic ifire, ofire;
    @(negedge clk);
    rst = r; flush_i = f; in_valid = iv; din = p; out_ready = ordy;
    #1;
    check("in_ready",  128'(in_ready),  128'(!r && q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(q.size() > 0));
    check("occupancy", 128'(occupancy), 128'(q.size()));
    check("payload",   128'(dout),      128'(q.size() > 0 ? q[0] : bubble()));
    if (prev_hold) check("stall_stable", 128'(dout), 128'(prev_out));
    ifire     = iv && !r && q.size() < 2;
    ofire     = ordy && q.size() > 0;
    prev_hold = !ofire && q.size() > 0 && !r && !f;
    prev_out  = dout;
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      if (ofire) q.delete(0);
      if (ifire) q.push_back(p);
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);

    // Reset held with a valid input pending; then a 4-entry back-to-back stream.
    cyc(1'b1, 1'b0, 1'b1, mk(5'd9, 1'b0), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, mk(5'(i), 1'b0), 1'b1);
      #1;
      check("stream_valid", 128'(out_valid), 128'(1));
      check("stream_wd",    128'(mem_wd),    128'(i));
      check("stream_occ",   128'(occupancy), 128'(1));
      check("stream_rdy",   128'(in_ready),  128'(1));
    end
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b1);

    // Backpressure fills the skid entry.
    cyc(1'b0, 1'b0, 1'b1, mk(5'd5, 1'b0), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(5'd6, 1'b0), 1'b0);
    #1;
    check("bp_occ", 128'(occupancy), 128'(2));
    check("bp_rdy", 128'(in_ready),  128'(0));
    check("bp_wd",  128'(mem_wd),    128'(5));
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b1);
    #1;
    check("bp_wd2", 128'(mem_wd), 128'(6));
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b1);
    #1;
    check("bp_bubble_valid", 128'(out_valid), 128'(0));
    check("bp_bubble_wreg",  128'(mem_wreg),  128'(0));
    check("bp_bubble_aluop", 128'(aluop_o),   128'(NOP));

    // Flush while full of stores, with a new input offered in the same cycle.
    cyc(1'b0, 1'b0, 1'b1, mk(5'd10, 1'b1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(5'd11, 1'b1), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, mk(5'd12, 1'b1), 1'b0);
    #1;
    check("flush_occ",   128'(occupancy), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_rw",    128'(mem_rw_o),  128'(0));
    repeat (2) cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b1);

    // Simultaneous accept and consume while holding one entry.
    cyc(1'b0, 1'b0, 1'b1, mk(5'd7, 1'b0), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(5'd8, 1'b0), 1'b1);
    #1;
    check("sim_wd",  128'(mem_wd),    128'(8));
    check("sim_occ", 128'(occupancy), 128'(1));
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b1);

    // Reset while full with a pending input.
    cyc(1'b0, 1'b0, 1'b1, mk(5'd13, 1'b1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, mk(5'd14, 1'b1), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, mk(5'd15, 1'b1), 1'b0);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_occ",   128'(occupancy), 128'(0));
    check("rst_wd",    128'(mem_wd),    128'(0));
    check("rst_aluop", 128'(aluop_o),   128'(NOP));
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0), 1'b0);

    // Randomized handshakes with occasional flush and reset.
    for (int n = 0; n < 10000; n++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7, mk(5'($urandom()), 1'($urandom())),
          $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
